// File: rtl/wave_phase_gen.sv
// Phase-accumulator NCO feeding the waveform ROM; o_phase_count is the new acc one cycle after an enabled add.
// FTW input is always ready in IDLE, and in RUN is held off while a shadow word waits for the next wrap; PHASE_DITHER_EN adds LFSR output dither.
module wave_phase_gen #(
  parameter int ACC_WIDTH = 32,
  parameter int DEPTH     = 1024,
  parameter int CYC_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_en,
  input  logic                       i_start,
  input  logic                       i_stop,
  input  logic [CYC_WIDTH-1:0]       i_burst_len,
  input  logic [ACC_WIDTH-1:0]       i_ftw,
  input  logic                       i_ftw_valid,
  output logic                       o_ftw_ready,
  output logic [$clog2(DEPTH)-1:0]   o_phase_count,
  output logic                       o_phase_valid,
  output logic                       o_wrap,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [ACC_WIDTH-1:0]  ftw_active_q, ftw_active_d;
  logic [ACC_WIDTH-1:0]  shadow_q, shadow_d;
  logic                  shadow_vld_q, shadow_vld_d;
  logic [CYC_WIDTH-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CYC_WIDTH-1:0]  len_q, len_d;
  logic                  phase_vld_q, phase_vld_d;
  logic                  wrap_q, wrap_d;
  logic                  done_q, done_d;
  logic [ACC_WIDTH:0]    add_full;
  logic                  ftw_xfer;

  assign add_full    = {1'b0, acc_q} + {1'b0, ftw_active_q};
  assign cnt_inc     = cnt_q + CYC_WIDTH'(1);
  assign o_ftw_ready = (state_q == IDLE) | ~shadow_vld_q;
  assign ftw_xfer    = i_ftw_valid & o_ftw_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_active_q <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      cnt_q        <= '0;
      len_q        <= '0;
      phase_vld_q  <= 1'b0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_active_q <= ftw_active_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      phase_vld_q  <= phase_vld_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_active_d = ftw_active_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    phase_vld_d  = 1'b0;
    wrap_d       = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        // A word parked in the shadow when playback was stopped is applied here.
        if (shadow_vld_q) begin
          ftw_active_d = shadow_q;
          shadow_vld_d = 1'b0;
        end
        if (ftw_xfer) ftw_active_d = i_ftw;
        if (i_start && !i_stop) begin
          state_d = RUN;
          cnt_d   = '0;
          len_d   = i_burst_len;
        end
      end
      RUN: begin
        if (ftw_xfer) begin
          shadow_d     = i_ftw;
          shadow_vld_d = 1'b1;
        end
        if (i_stop) begin
          state_d = IDLE;
          acc_d   = '0;
        end else if (i_start) begin
          acc_d = '0;
          cnt_d = '0;
          len_d = i_burst_len;
        end else if (i_en) begin
          acc_d       = add_full[ACC_WIDTH-1:0];
          phase_vld_d = 1'b1;
          wrap_d      = add_full[ACC_WIDTH];
          if (add_full[ACC_WIDTH]) begin
            // Swap tuning word at the period boundary so the phase stays continuous.
            if (shadow_vld_q) begin
              ftw_active_d = shadow_q;
              shadow_vld_d = 1'b0;
            end
            if (cnt_q != '1) cnt_d = cnt_inc;
            if ((len_q != '0) && (cnt_inc == len_q)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_phase_valid = phase_vld_q;
  assign o_wrap        = wrap_q;
  assign o_done        = done_q;
  assign o_busy        = (state_q == RUN);

`ifdef PHASE_DITHER_EN
  localparam int DW = ((ACC_WIDTH - PW) < 16) ? (ACC_WIDTH - PW) : 16;

  logic [15:0]          lfsr_q;
  logic                 lfsr_fb;
  logic [ACC_WIDTH-1:0] phase_sum;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      lfsr_q <= 16'hACE1;
    end else if ((state_q == RUN) && i_en && !i_stop) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end

  // Dither only touches bits below the address, so the output moves by at most one step.
  assign phase_sum     = acc_q + ACC_WIDTH'(lfsr_q[DW-1:0]);
  assign o_phase_count = phase_sum[ACC_WIDTH-1 -: PW];
`else
  assign o_phase_count = acc_q[ACC_WIDTH-1 -: PW];
`endif

endmodule

// File: tb/tb_wave_phase_gen.sv
// Scoreboarded bench for wave_phase_gen (ACC_WIDTH=32, DEPTH=1024, dither off).
module tb_wave_phase_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, start, stop, ftw_valid;
  logic [15:0] burst_len;
  logic [31:0] ftw;
  logic        ftw_ready;
  logic [9:0]  phase_count;
  logic        phase_valid, wrap, busy, done;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [9:0] phase;
    logic       wrap;
    logic       done;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  wave_phase_gen #(.ACC_WIDTH(32), .DEPTH(1024), .CYC_WIDTH(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_start       (start),
    .i_stop        (stop),
    .i_burst_len   (burst_len),
    .i_ftw         (ftw),
    .i_ftw_valid   (ftw_valid),
    .o_ftw_ready   (ftw_ready),
    .o_phase_count (phase_count),
    .o_phase_valid (phase_valid),
    .o_wrap        (wrap),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input int ph, input logic w, input logic d, input logic b);
    exp_t e;
    e.phase = ph[9:0];
    e.wrap  = w;
    e.done  = d;
    e.busy  = b;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_phase"}, 32'(phase_count), 32'd0);
    chk({tag, "_valid"}, 32'(phase_valid), 32'd0);
    chk({tag, "_wrap"},  32'(wrap), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(ftw_ready), 32'd1);
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (phase_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_valid: got phase %0d with no expectation at %0t", phase_count, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_phase", 32'(phase_count), 32'(e.phase));
        chk("sb_wrap",  32'(wrap),        32'(e.wrap));
        chk("sb_done",  32'(done),        32'(e.done));
        chk("sb_busy",  32'(busy),        32'(e.busy));
      end
    end
  end

  initial begin
    int p;
    rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0;
    ftw_valid = 1'b0; burst_len = '0; ftw = '0;
    tick(); tick();
    rst = 1'b0;
    chk_idle_outputs("reset");

    // Continuous playback, step of one address per cycle, two full periods.
    ftw = 32'h0040_0000; ftw_valid = 1'b1; tick();
    ftw_valid = 1'b0;
    chk("idle_ready_after_load", 32'(ftw_ready), 32'd1);
    start = 1'b1; burst_len = 16'd0; tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    en = 1'b1;
    for (int k = 1; k <= 2048; k++) begin
      push(k % 1024, (k % 1024) == 0, 1'b0, 1'b1);
      tick();
    end

    // Enable gating: 1,0,1,0.
    p = 0;
    for (int i = 0; i < 4; i++) begin
      en = (i % 2 == 0);
      if (en) begin
        p++;
        push(p, 1'b0, 1'b0, 1'b1);
      end
      tick();
      chk("en_gate_valid", 32'(phase_valid), 32'(en));
      chk("en_gate_phase", 32'(phase_count), 32'(p));
    end

    // Mid-run FTW change: held in shadow until the wrap, then step of 2.
    ftw = 32'h0080_0000; ftw_valid = 1'b1; en = 1'b1;
    push(3, 1'b0, 1'b0, 1'b1);
    tick();
    ftw_valid = 1'b0;
    chk("shadow_ready_low", 32'(ftw_ready), 32'd0);
    for (int q = 4; q <= 1024; q++) begin
      push(q % 1024, q == 1024, 1'b0, 1'b1);
      tick();
      if (q == 1023 || q == 1024) chk("shadow_ready", 32'(ftw_ready), 32'(q == 1024));
    end
    for (int k = 1; k <= 10; k++) begin
      push(2 * k, 1'b0, 1'b0, 1'b1);
      tick();
    end
    en = 1'b0; stop = 1'b1; tick();
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_phase", 32'(phase_count), 32'd0);

    // Burst of 3 periods, 16 addresses per cycle.
    ftw = 32'h0400_0000; ftw_valid = 1'b1; tick();
    ftw_valid = 1'b0;
    start = 1'b1; burst_len = 16'd3; tick();
    start = 1'b0;
    en = 1'b1;
    for (int k = 1; k <= 192; k++) begin
      push((16 * k) % 1024, (k % 64) == 0, k == 192, k != 192);
      tick();
    end
    tick();
    chk("burst_end_phase", 32'(phase_count), 32'd0);
    chk("burst_end_valid", 32'(phase_valid), 32'd0);
    chk("burst_end_done",  32'(done), 32'd0);
    chk("burst_end_busy",  32'(busy), 32'd0);

    // Stop coincides with the wrap that would complete a 1-period burst.
    en = 1'b0; start = 1'b1; burst_len = 16'd1; tick();
    start = 1'b0; en = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      push(16 * k, 1'b0, 1'b0, 1'b1);
      tick();
    end
    stop = 1'b1; tick();
    stop = 1'b0;
    chk("stop_wrap_done",  32'(done), 32'd0);
    chk("stop_wrap_busy",  32'(busy), 32'd0);
    chk("stop_wrap_valid", 32'(phase_valid), 32'd0);
    chk("stop_wrap_wrap",  32'(wrap), 32'd0);

    // Restart while running returns to phase 0.
    en = 1'b0; start = 1'b1; burst_len = 16'd0; tick();
    start = 1'b0; en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      push(16 * k, 1'b0, 1'b0, 1'b1);
      tick();
    end
    start = 1'b1; tick();
    start = 1'b0;
    chk("restart_phase", 32'(phase_count), 32'd0);
    chk("restart_valid", 32'(phase_valid), 32'd0);
    chk("restart_busy",  32'(busy), 32'd1);
    push(16, 1'b0, 1'b0, 1'b1);
    tick();

    // Reset mid-run with a shadow word pending.
    ftw = 32'h0100_0000; ftw_valid = 1'b1;
    push(32, 1'b0, 1'b0, 1'b1);
    tick();
    ftw_valid = 1'b0;
    chk("pre_reset_ready", 32'(ftw_ready), 32'd0);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk_idle_outputs("midrun_reset");
    en = 1'b0; tick();
    start = 1'b1; tick();
    start = 1'b0; en = 1'b1;
    // Tuning word is zero after reset: accumulator frozen, valid still follows enable.
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, 1'b0, 1'b1);
      tick();
    end

    en = 1'b0; tick(); tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
